// File: rtl/accumulator_readout_unit.sv
// Accumulator readout: streams finished rows out of the accumulator, requantizes each
// 32-lane row to int8 (ReLU, rounding shift, saturation) and writes it to the unified buffer.
module accumulator_readout_unit #(
    parameter int MUL_SIZE   = 32,
    parameter int ACC_W      = 32,
    parameter int ACC_ADDR_W = 10,
    parameter int UB_ADDR_W  = 12
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic [7:0]                  V_dim_i,
    input  logic [7:0]                  U_dim_i,
    input  logic [4:0]                  shift_i,
    input  logic                        relu_en_i,
    input  logic [UB_ADDR_W-1:0]        ub_base_addr_i,
    output logic                        accum_rd_en_o,
    output logic [ACC_ADDR_W-1:0]       accum_rd_addr_o,
    input  logic [MUL_SIZE*ACC_W-1:0]   accum_rd_data_i,
    output logic                        ub_wr_valid_o,
    input  logic                        ub_ready_i,
    output logic [UB_ADDR_W-1:0]        ub_wr_addr_o,
    output logic [MUL_SIZE*8-1:0]       ub_wr_data_o,
    output logic                        busy_o,
    output logic                        done_o
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                  r_state;
    state_t                  w_stateNext;
    logic [15:0]             r_rows;
    logic [15:0]             r_rdIdx;
    logic [15:0]             w_rowsIn;
    logic [4:0]              r_shift;
    logic                    r_relu;
    logic [UB_ADDR_W-1:0]    r_wrAddr;
    logic                    r_rdPend;
    logic [MUL_SIZE*8-1:0]   r_fifoMem [2];
    logic                    r_head;
    logic                    r_tail;
    logic [1:0]              r_count;
    logic [2:0]              w_credit;
    logic                    w_rdEn;
    logic                    w_lastRead;
    logic                    w_push;
    logic                    w_pop;
    logic [MUL_SIZE*8-1:0]   w_rowOut;

    function automatic logic [7:0] requant(input logic signed [ACC_W-1:0] acc,
                                           input logic [4:0] sh,
                                           input logic relu);
        logic signed [ACC_W:0] x;
        logic signed [ACC_W:0] rnd;
        if (relu && acc < 0)
            x = '0;
        else
            x = (ACC_W+1)'(acc);
        if (sh != 5'd0) begin
            rnd = (ACC_W+1)'(1) << (sh - 5'd1);
            x   = (x + rnd) >>> sh;
        end
        if (x > 33'sd127)
            return 8'h7F;
        else if (x < -33'sd128)
            return 8'h80;
        else
            return x[7:0];
    endfunction

    assign w_rowsIn = 16'(V_dim_i) * 16'(U_dim_i / 8'(MUL_SIZE));

    assign ub_wr_valid_o   = (r_count != 2'd0);
    assign ub_wr_addr_o    = r_wrAddr;
    assign ub_wr_data_o    = r_fifoMem[r_head];
    assign w_pop           = ub_wr_valid_o & ub_ready_i;
    assign w_push          = r_rdPend;

    // Credit counts rows already buffered or in flight, minus the one leaving this cycle,
    // so a full-rate stream never issues a read the 2-entry FIFO cannot absorb.
    assign w_credit        = {1'b0, r_count} + {2'b00, r_rdPend} - {2'b00, w_pop};
    assign w_rdEn          = (r_state == S_ISSUE) && (w_credit < 3'd2);
    assign w_lastRead      = w_rdEn && (r_rdIdx == r_rows - 16'd1);
    assign accum_rd_en_o   = w_rdEn;
    assign accum_rd_addr_o = r_rdIdx[ACC_ADDR_W-1:0];

    always_comb begin
        w_rowOut = '0;
        for (int i = 0; i < MUL_SIZE; i++)
            w_rowOut[i*8 +: 8] = requant(accum_rd_data_i[i*ACC_W +: ACC_W], r_shift, r_relu);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_rows       <= '0;
            r_rdIdx      <= '0;
            r_shift      <= '0;
            r_relu       <= 1'b0;
            r_wrAddr     <= '0;
            r_rdPend     <= 1'b0;
            r_fifoMem[0] <= '0;
            r_fifoMem[1] <= '0;
            r_head       <= 1'b0;
            r_tail       <= 1'b0;
            r_count      <= '0;
        end else begin
            r_state  <= w_stateNext;
            r_rdPend <= w_rdEn;
            if (r_state == S_IDLE && start_i) begin
                r_rows   <= w_rowsIn;
                r_rdIdx  <= '0;
                r_shift  <= shift_i;
                r_relu   <= relu_en_i;
                r_wrAddr <= ub_base_addr_i;
            end else begin
                if (w_rdEn)
                    r_rdIdx <= r_rdIdx + 16'd1;
                if (w_pop)
                    r_wrAddr <= r_wrAddr + 1'b1;
            end
            if (w_push) begin
                r_fifoMem[r_tail] <= w_rowOut;
                r_tail            <= ~r_tail;
            end
            if (w_pop)
                r_head <= ~r_head;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // DRAIN ends once nothing is in flight and the FIFO empties this cycle.
    always_comb begin
        w_stateNext = r_state;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i)
                    w_stateNext = (w_rowsIn == 16'd0) ? S_DONE : S_ISSUE;
            end
            S_ISSUE: begin
                busy_o = 1'b1;
                if (w_lastRead)
                    w_stateNext = S_DRAIN;
            end
            S_DRAIN: begin
                busy_o = 1'b1;
                if (!r_rdPend && (r_count == 2'd0 || (r_count == 2'd1 && w_pop)))
                    w_stateNext = S_DONE;
            end
            S_DONE: begin
                done_o      = 1'b1;
                w_stateNext = S_IDLE;
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_accumulator_readout_unit.sv
// Scoreboard bench for accumulator_readout_unit: a behavioural accumulator feeds rows,
// expected UB writes are queued at read time and compared when the UB accepts them.
module tb_accumulator_readout_unit;

    localparam int ROW_W = 32 * 32;
    localparam int OUT_W = 32 * 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [7:0]         vDim = '0;
    logic [7:0]         uDim = '0;
    logic [4:0]         shiftAmt = '0;
    logic               reluEn = 1'b0;
    logic [11:0]        ubBase = '0;
    logic               rdEn;
    logic [9:0]         rdAddr;
    logic [ROW_W-1:0]   rdData = '0;
    logic               wrValid;
    logic               ubReady = 1'b0;
    logic [11:0]        wrAddr;
    logic [OUT_W-1:0]   wrData;
    logic               busy;
    logic               done;

    accumulator_readout_unit dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .V_dim_i(vDim), .U_dim_i(uDim), .shift_i(shiftAmt), .relu_en_i(reluEn),
        .ub_base_addr_i(ubBase),
        .accum_rd_en_o(rdEn), .accum_rd_addr_o(rdAddr), .accum_rd_data_i(rdData),
        .ub_wr_valid_o(wrValid), .ub_ready_i(ubReady),
        .ub_wr_addr_o(wrAddr), .ub_wr_data_o(wrData),
        .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0]      addr;
        logic [OUT_W-1:0] data;
    } sbEntry_t;

    sbEntry_t          sbQueue[$];
    sbEntry_t          sbEntry;
    sbEntry_t          sbHead;
    int                errorCount = 0;
    int                checkCount = 0;
    int                gMode = 0;
    logic [4:0]        gShift = '0;
    bit                gRelu = 1'b0;
    logic [11:0]       gBase = '0;
    int                readyMode = 0;
    int                negCnt = 0;
    int                startNeg = 0;
    int                doneNeg = 0;
    int                doneCount = 0;
    int                readCount = 0;
    int                writeCount = 0;
    int                maxOut = 0;
    bit                prevStall = 1'b0;
    logic [11:0]       stallAddr = '0;
    logic [OUT_W-1:0]  stallData = '0;
    logic [11:0]       firstAccAddr = '0;
    logic [11:0]       lastAccAddr = '0;
    logic [OUT_W-1:0]  firstAccData = '0;
    logic [OUT_W-1:0]  lastAccData = '0;

    task automatic checkOutput(input string tag, input logic [OUT_W-1:0] actual,
                               input logic [OUT_W-1:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Accumulator contents for each stimulus mode: constant, fixed lane pattern, address-dependent.
    function automatic logic [ROW_W-1:0] genRow(input int mode, input int addr);
        logic [ROW_W-1:0] r;
        int v;
        int pat[4];
        pat = '{-300, 300, 1000, -7};
        r = '0;
        for (int i = 0; i < 32; i++) begin
            case (mode)
                0:       v = 5;
                1:       v = pat[i % 4];
                default: v = ((addr * 131 + i * 977) % 60000) - 30000;
            endcase
            r[i*32 +: 32] = v;
        end
        return r;
    endfunction

    // Reference requantization using integer floor division on wide values.
    function automatic logic [OUT_W-1:0] refRow(input logic [ROW_W-1:0] row, input int sh, input bit relu);
        logic [OUT_W-1:0] o;
        longint x;
        longint d;
        longint q;
        o = '0;
        for (int i = 0; i < 32; i++) begin
            x = longint'(signed'(row[i*32 +: 32]));
            if (relu && x < 0)
                x = 0;
            if (sh > 0) begin
                d = longint'(1) << sh;
                q = x + d / 2;
                if (q >= 0)
                    x = q / d;
                else
                    x = -((-q + d - 1) / d);
            end
            if (x > 127)
                x = 127;
            if (x < -128)
                x = -128;
            o[i*8 +: 8] = 8'(x);
        end
        return o;
    endfunction

    initial begin
        logic [9:0] a;
        forever begin
            @(posedge clk);
            if (rdEn && !rst) begin
                a = rdAddr;
                #1 rdData = genRow(gMode, int'(a));
            end
        end
    end

    initial begin
        int phase;
        phase = 0;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0: ubReady = 1'b1;
                1: begin
                    ubReady = (phase == 0);
                    phase   = (phase + 1) % 3;
                end
                default: ubReady = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        negCnt++;
        if (rst) begin
            prevStall = 1'b0;
        end else begin
            if (start && !busy)
                startNeg = negCnt;
            if (prevStall) begin
                checkOutput("stall_valid", wrValid, 1);
                checkOutput("stall_addr", wrAddr, stallAddr);
                checkOutput("stall_data", wrData, stallData);
            end
            if (rdEn) begin
                checkOutput("rd_addr", rdAddr, 10'(readCount));
                sbEntry.addr = 12'(gBase + readCount);
                sbEntry.data = refRow(genRow(gMode, readCount % 1024), int'(gShift), gRelu);
                sbQueue.push_back(sbEntry);
                readCount++;
            end
            if (wrValid && ubReady) begin
                checkOutput("sb_pending", sbQueue.size() != 0, 1);
                if (sbQueue.size() != 0) begin
                    sbHead = sbQueue.pop_front();
                    checkOutput("wr_addr", wrAddr, sbHead.addr);
                    checkOutput("wr_data", wrData, sbHead.data);
                end
                if (writeCount == 0) begin
                    firstAccAddr = wrAddr;
                    firstAccData = wrData;
                end
                lastAccAddr = wrAddr;
                lastAccData = wrData;
                writeCount++;
            end
            prevStall = wrValid && !ubReady;
            stallAddr = wrAddr;
            stallData = wrData;
            if (readCount - writeCount > maxOut)
                maxOut = readCount - writeCount;
            if (done) begin
                doneCount++;
                doneNeg = negCnt;
                checkOutput("busy_at_done", busy, 0);
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] v, input logic [7:0] u, input logic [4:0] sh,
                                 input bit relu, input logic [11:0] base, input int mode,
                                 input int rdyMode);
        gMode      = mode;
        gShift     = sh;
        gRelu      = relu;
        gBase      = base;
        readyMode  = rdyMode;
        readCount  = 0;
        writeCount = 0;
        maxOut     = 0;
        doneCount  = 0;
        @(posedge clk);
        #1;
        vDim     = v;
        uDim     = u;
        shiftAmt = sh;
        reluEn   = relu;
        ubBase   = base;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget, input string tag);
        int n;
        n = 0;
        while (doneCount == 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        checkOutput(tag, doneCount != 0, 1);
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ctrl", {rdEn, rdAddr, wrValid, wrAddr, busy, done}, '0);
        checkOutput("reset_data", wrData, '0);
        rst = 1'b0;

        // Constant lanes, full-rate drain, latency from start to done.
        applyStimulus(8'd4, 8'd32, 5'd0, 1'b0, 12'd20, 0, 0);
        waitDone(50, "t1_done");
        checkOutput("t1_writes", writeCount, 4);
        checkOutput("t1_latency", doneNeg - startNeg, 7);
        checkOutput("t1_data", firstAccData, {32{8'h05}});
        checkOutput("t1_first_addr", firstAccAddr, 12'd20);
        checkOutput("t1_last_addr", lastAccAddr, 12'd23);
        checkOutput("t1_sb_empty", sbQueue.size(), 0);

        // Rounding shift and saturation, then the same lanes through ReLU.
        applyStimulus(8'd1, 8'd32, 5'd2, 1'b0, 12'd0, 1, 0);
        waitDone(30, "t2_done");
        checkOutput("t2_lanes", lastAccData[31:0], 32'hFE7F4BB5);
        applyStimulus(8'd1, 8'd32, 5'd2, 1'b1, 12'd0, 1, 0);
        waitDone(30, "t2r_done");
        checkOutput("t2_relu_lanes", lastAccData[31:0], 32'h007F4B00);

        // 16 rows under periodic backpressure.
        applyStimulus(8'd8, 8'd64, 5'd6, 1'b0, 12'd100, 2, 1);
        waitDone(400, "t3_done");
        checkOutput("t3_writes", writeCount, 16);
        checkOutput("t3_reads", readCount, 16);
        checkOutput("t3_outstanding", maxOut <= 2, 1);
        checkOutput("t3_last_addr", lastAccAddr, 12'd115);
        checkOutput("t3_sb_empty", sbQueue.size(), 0);

        // Zero-row job: no traffic, prompt done.
        applyStimulus(8'd5, 8'd0, 5'd0, 1'b0, 12'd0, 0, 0);
        waitDone(20, "t4_done");
        checkOutput("t4_reads", readCount, 0);
        checkOutput("t4_writes", writeCount, 0);
        checkOutput("t4_done_delay", (doneNeg - startNeg >= 1) && (doneNeg - startNeg <= 2), 1);

        // A second start while busy must not change the job.
        applyStimulus(8'd4, 8'd32, 5'd0, 1'b0, 12'd200, 0, 0);
        @(posedge clk);
        #1;
        vDim  = 8'd8;
        uDim  = 8'd64;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(50, "t4b_done");
        repeat (3) @(posedge clk);
        checkOutput("t4b_writes", writeCount, 4);
        checkOutput("t4b_reads", readCount, 4);
        checkOutput("t4b_done_count", doneCount, 1);
        checkOutput("t4b_last_addr", lastAccAddr, 12'd203);

        // Asynchronous reset while stuck in DRAIN.
        applyStimulus(8'd2, 8'd32, 5'd0, 1'b0, 12'd0, 1, 2);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("t5_stalled", {busy, wrValid, rdEn}, 3'b110);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t5_reset_ctrl", {rdEn, rdAddr, wrValid, wrAddr, busy, done}, '0);
        checkOutput("t5_reset_data", wrData, '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sbQueue.delete();
        readyMode = 0;
        repeat (4) @(posedge clk);
        checkOutput("t5_no_done", doneCount, 0);

        // UB address wrap after reset.
        applyStimulus(8'd4, 8'd32, 5'd0, 1'b0, 12'd4094, 1, 0);
        waitDone(50, "t6_done");
        checkOutput("t6_writes", writeCount, 4);
        checkOutput("t6_first_addr", firstAccAddr, 12'd4094);
        checkOutput("t6_last_addr", lastAccAddr, 12'd1);
        checkOutput("t6_sb_empty", sbQueue.size(), 0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
